fir_adder_tree: RTL and testbench

Parametrised, pipelined multi-operand signed adder for the FIR datapath. It replaces the two-input registered `adder` at the tap-summation point. It sums `NUM_IN` signed `N`-bit products per sample through a binary tree, with a valid flag travelling alongside the data, a global stall, and optional output saturation. Throughput is one sample vector per enabled cycle.

---
 rtl/fir_adder_tree_if.sv | 23 ++
 rtl/fir_adder_tree.sv | 105 ++++++++++
 tb/tb_fir_adder_tree.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fir_adder_tree_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_adder_tree_if
// Purpose  : Sample-vector bus between the FIR tap multipliers and the adder tree.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_adder_tree_if #(
    parameter int N      = 8,
    parameter int NUM_IN = 4
);
    localparam int c_out_w = N + $clog2(NUM_IN);

    logic                      en;
    logic                      in_valid;
    logic [NUM_IN*N-1:0]       din;
    logic                      out_valid;
    logic signed [c_out_w-1:0] res;
    logic                      sat;

    modport master (output en, in_valid, din, input out_valid, res, sat);
    modport slave  (input en, in_valid, din, output out_valid, res, sat);
endinterface
`default_nettype wire

// File: rtl/fir_adder_tree.sv
`default_nettype none
// ============================================================================
// Module   : fir_adder_tree
// Purpose  : Pipelined signed multi-operand adder tree with valid/stall tracking.
//            Optional output clamping enabled by macro FIR_ADDER_TREE_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fir_adder_tree #(
    parameter int N      = 8,
    parameter int NUM_IN = 4,
    parameter int PIPE   = 1
) (
    input  logic             clk,
    input  logic             rst,
    fir_adder_tree_if.slave  bus
);
    localparam int c_lvl    = $clog2(NUM_IN);
    localparam int c_out_w  = N + c_lvl;
    localparam int c_nodes  = 2 * NUM_IN - 1;
    localparam int c_root   = 2 * NUM_IN - 2;
    localparam int c_stages = (PIPE != 0) ? c_lvl : 1;

    // Heap-ordered tree: leaves 0..NUM_IN-1, level k starts at 2*(NUM_IN - NUM_IN>>k).
    logic signed [c_out_w-1:0] w_node [c_nodes];
    logic [c_stages:0]         w_vchain;
    logic [c_stages-1:0]       r_vld;

    logic signed [c_out_w-1:0] r_res;
    logic                      r_sat;
    logic signed [c_out_w-1:0] w_final;
    logic                      w_sat;

    assign w_vchain = {r_vld, bus.in_valid};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_leaf
        assign w_node[i] = {{c_lvl{bus.din[i*N+N-1]}}, bus.din[i*N +: N]};
    end

    for (genvar k = 1; k <= c_lvl; k++) begin : g_lvl
        for (genvar m = 0; m < (NUM_IN >> k); m++) begin : g_node
            localparam int c_j = 2 * (NUM_IN - (NUM_IN >> k)) + m;
            localparam int c_a = 2 * (NUM_IN - (NUM_IN >> (k - 1))) + 2 * m;
            logic signed [c_out_w-1:0] w_sum;

            assign w_sum = w_node[c_a] + w_node[c_a + 1];

            if ((PIPE != 0) && (c_j != c_root)) begin : g_reg
                logic signed [c_out_w-1:0] r_q;
                always_ff @(posedge clk) begin
                    if (!rst)
                        r_q <= '0;
                    else if (bus.en && w_vchain[k-1])
                        r_q <= w_sum;
                end
                assign w_node[c_j] = r_q;
            end else begin : g_comb
                // The root is always captured by the shared output stage below.
                assign w_node[c_j] = w_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_vld <= '0;
        else if (bus.en)
            r_vld <= w_vchain[c_stages-1:0];
    end

`ifdef FIR_ADDER_TREE_SAT_EN
    localparam logic signed [c_out_w-1:0] c_max = c_out_w'((longint'(1) << (N - 1)) - 1);
    localparam logic signed [c_out_w-1:0] c_min = ~c_max;

    always_comb begin
        w_final = w_node[c_root];
        w_sat   = 1'b0;
        if (w_node[c_root] > c_max) begin
            w_final = c_max;
            w_sat   = 1'b1;
        end else if (w_node[c_root] < c_min) begin
            w_final = c_min;
            w_sat   = 1'b1;
        end
    end
`else
    assign w_final = w_node[c_root];
    assign w_sat   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_res <= '0;
            r_sat <= 1'b0;
        end else if (bus.en && w_vchain[c_stages-1]) begin
            r_res <= w_final;
            r_sat <= w_sat;
        end
    end

    assign bus.res       = r_res;
    assign bus.sat       = r_sat;
    assign bus.out_valid = w_vchain[c_stages];

endmodule
`default_nettype wire

// File: tb/tb_fir_adder_tree.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_adder_tree
// Purpose  : Self-checking bench driving PIPE=1 and PIPE=0 instances in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_adder_tree;
    localparam int N      = 8;
    localparam int NUM_IN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [31:0] din;

    always #5 clk = ~clk;

    fir_adder_tree_if #(.N(N), .NUM_IN(NUM_IN)) b1 ();
    fir_adder_tree_if #(.N(N), .NUM_IN(NUM_IN)) b0 ();

    assign b1.en = en;  assign b1.in_valid = in_valid;  assign b1.din = din;
    assign b0.en = en;  assign b0.in_valid = in_valid;  assign b0.din = din;

    fir_adder_tree #(.N(N), .NUM_IN(NUM_IN), .PIPE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    fir_adder_tree #(.N(N), .NUM_IN(NUM_IN), .PIPE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: list of accepted samples stamped with their enabled-edge number.
    int ecount = 0;
    int acc_cnt[$];
    int acc_val[$];
    int head[2]  = '{0, 0};
    int lat[2]   = '{1, 2};
    int exp_v[2] = '{0, 0};
    int exp_r[2] = '{0, 0};
    int exp_s[2] = '{0, 0};

    function automatic int vsum(input logic [31:0] d);
        int s = 0;
        for (int i = 0; i < NUM_IN; i++) s += int'($signed(d[i*8 +: 8]));
        return s;
    endfunction

    function automatic void clampv(input int s, output int r, output int f);
`ifdef FIR_ADDER_TREE_SAT_EN
        if (s > 127)       begin r = 127;  f = 1; end
        else if (s < -128) begin r = -128; f = 1; end
        else               begin r = s;    f = 0; end
`else
        r = s;
        f = 0;
`endif
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic v, input logic [31:0] d);
        if (!r) begin
            for (int k = 0; k < 2; k++) begin
                head[k] = acc_cnt.size();
                exp_v[k] = 0; exp_r[k] = 0; exp_s[k] = 0;
            end
        end else if (e) begin
            ecount++;
            if (v) begin
                acc_cnt.push_back(ecount);
                acc_val.push_back(vsum(d));
            end
            for (int k = 0; k < 2; k++) begin
                if (head[k] < acc_cnt.size() && acc_cnt[head[k]] + lat[k] - 1 == ecount) begin
                    exp_v[k] = 1;
                    clampv(acc_val[head[k]], exp_r[k], exp_s[k]);
                    head[k]++;
                end else begin
                    exp_v[k] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("pipe1_out_valid", {31'b0, b1.out_valid}, exp_v[1]);
        chk("pipe1_res",       32'($signed(b1.res)),  exp_r[1]);
        chk("pipe1_sat",       {31'b0, b1.sat},       exp_s[1]);
        chk("pipe0_out_valid", {31'b0, b0.out_valid}, exp_v[0]);
        chk("pipe0_res",       32'($signed(b0.res)),  exp_r[0]);
        chk("pipe0_sat",       {31'b0, b0.sat},       exp_s[0]);
    endtask

    // Drive at the falling edge, update the model at the rising edge, check at the next fall.
    task automatic step(input logic r, input logic e, input logic v, input logic [31:0] d);
        rst = r; en = e; in_valid = v; din = d;
        @(posedge clk);
        model_edge(r, e, v, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, $urandom());
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; in_valid = 1'b0; din = '0;

        // Reset with random activity on the inputs
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
        idle(1);

        // Single sample {2,4,5,8} -> 19, then hold
        step(1'b1, 1'b1, 1'b1, 32'h0805_0402);
        idle(4);

        // Extremes and an in-range sum
        step(1'b1, 1'b1, 1'b1, 32'h8080_8080);
        idle(2);
        step(1'b1, 1'b1, 1'b1, 32'h7F7F_7F7F);
        idle(2);
        step(1'b1, 1'b1, 1'b1, 32'h0805_0402);
        idle(3);

        // Streaming {2,4}, {5,8}, {11,3} -> 6, 13, 14
        step(1'b1, 1'b1, 1'b1, 32'h0000_0402);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0805);
        step(1'b1, 1'b1, 1'b1, 32'h0000_030B);
        idle(3);

        // Single-cycle gap in the input stream
        step(1'b1, 1'b1, 1'b1, 32'h0102_0304);
        step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 1'b1, 32'hF0F1_F2F3);
        idle(3);

        // Stall with two samples in flight
        step(1'b1, 1'b1, 1'b1, 32'h1020_3040);
        step(1'b1, 1'b1, 1'b1, 32'hFEFD_FCFB);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom());
        idle(3);

        // Reset one cycle after accepting {1,1,1,1}
        step(1'b1, 1'b1, 1'b1, 32'h0101_0101);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        idle(3);

        // Randomised traffic with stalls and occasional reset
        for (int i = 0; i < 400; i++) begin
            logic       r_r;
            logic       r_e;
            logic       r_v;
            logic [31:0] r_d;
            r_r = ($urandom_range(0, 59) != 0);
            r_e = ($urandom_range(0, 3) != 0);
            r_v = 1'($urandom_range(0, 1));
            r_d = ($urandom_range(0, 3) == 0) ? $urandom() & 32'h1F1F_1F1F : $urandom();
            step(r_r, r_e, r_v, r_d);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
